// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding, default pattern, width helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package seq_pattern_pkg;

    // State encoding, 2-bit
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SHIFT = SHIFT,
        S_GAP   = GAP,
        S_DONE  = DONE
    } state_t;

    // Pattern recognised by the companion 1001 sequence detector
    localparam logic [3:0] SEQ_PAT_1001 = 4'b1001;

    // Width of a counter that must hold values 0..v-1; never less than 1 bit
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle between a pattern source and seq_pattern_tx.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the transmitter is idle.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             ser_out;
    logic             busy;
    logic             frame_last;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt,
        input  ser_out, busy, frame_last, done
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output ser_out, busy, frame_last, done
    );
endinterface

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register; msb is the next bit to be transmitted.
// Latency: load/shift take effect on the next rising edge; load has priority over shift.
// Backpressure: none; holds its value when neither load nor shift is asserted.
module seq_shift_reg
    import seq_pattern_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_a_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);
    logic [W-1:0] sr_q;

    // Load a new word or shift left by one, filling with zero
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= d;
        end else if (shift) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb = sr_q[W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, repeated N times, then pulses done.
// Latency: first bit on ser_out the cycle after start is accepted; done N*PAT_W + (N-1)*G + 1 cycles after start.
// Backpressure: start is ignored unless idle; optional SEQ_GAP_EN inserts GAP_LEN zero cycles between repeats.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_a_n,
    seq_pattern_tx_if.slave  bus
);
    localparam int             BCW     = clog2(PAT_W);
    localparam logic [BCW-1:0] BC_LAST = BCW'(PAT_W - 1);
`ifdef SEQ_GAP_EN
    localparam int             GCW     = clog2(GAP_LEN);
    localparam logic [GCW-1:0] GC_LAST = GCW'(GAP_LEN - 1);
`endif

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] reps_q;
    logic [BCW-1:0]   bitcnt_q;
`ifdef SEQ_GAP_EN
    logic [GCW-1:0]   gap_q;
`endif
    logic             ser_q;
    logic             busy_q;
    logic             last_q;
    logic             done_q;

    logic             sr_load_d;
    logic             sr_shift_d;
    logic [PAT_W-1:0] sr_src_d;
    logic [PAT_W-1:0] sr_dat_d;
    logic             sr_msb;

    // The MSB of a frame goes straight from pattern to ser_q, so the shift
    // register is loaded with the remaining bits already left-aligned and its
    // msb is always the next bit to send.
    always_comb begin
        sr_load_d  = 1'b0;
        sr_shift_d = 1'b0;
        sr_src_d   = pat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sr_load_d = 1'b1;
                    sr_src_d  = bus.pattern;
                end
            end
            S_SHIFT: begin
                if (bitcnt_q != '0) begin
                    sr_shift_d = 1'b1;
                end else if (reps_q > CNT_W'(1)) begin
                    sr_load_d = 1'b1;
                end
            end
            default: ;
        endcase
        sr_dat_d = {sr_src_d[PAT_W-2:0], 1'b0};
    end

    seq_shift_reg #(.W(PAT_W)) u_shreg (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .load    (sr_load_d),
        .shift   (sr_shift_d),
        .d       (sr_dat_d),
        .msb     (sr_msb)
    );

    // Control FSM with repeat, bit and gap counters; all outputs registered
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            reps_q   <= '0;
            bitcnt_q <= '0;
`ifdef SEQ_GAP_EN
            gap_q    <= '0;
`endif
            ser_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pat_q    <= bus.pattern;
                        reps_q   <= (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
                        bitcnt_q <= BC_LAST;
                        ser_q    <= bus.pattern[PAT_W-1];
                        busy_q   <= 1'b1;
                        last_q   <= 1'b0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bitcnt_q != '0) begin
                        bitcnt_q <= bitcnt_q - BCW'(1);
                        ser_q    <= sr_msb;
                        last_q   <= (bitcnt_q == BCW'(1));
                    end else if (reps_q > CNT_W'(1)) begin
                        reps_q <= reps_q - CNT_W'(1);
                        last_q <= 1'b0;
`ifdef SEQ_GAP_EN
                        ser_q   <= 1'b0;
                        gap_q   <= GC_LAST;
                        state_q <= S_GAP;
`else
                        bitcnt_q <= BC_LAST;
                        ser_q    <= pat_q[PAT_W-1];
`endif
                    end else begin
                        ser_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`ifdef SEQ_GAP_EN
                S_GAP: begin
                    if (gap_q == '0) begin
                        bitcnt_q <= BC_LAST;
                        ser_q    <= pat_q[PAT_W-1];
                        state_q  <= S_SHIFT;
                    end else begin
                        gap_q <= gap_q - GCW'(1);
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    ser_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ser_out    = ser_q;
    assign bus.busy       = busy_q;
    assign bus.frame_last = last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: vector table, hand sequences and randomized transfers.
// Latency: n/a (simulation only).
// Backpressure: n/a; builds with or without SEQ_GAP_EN.
module tb_seq_pattern_tx;
    import seq_pattern_pkg::*;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 4;
    localparam int GAP_LEN = 2;
`ifdef SEQ_GAP_EN
    localparam int G = GAP_LEN;
`else
    localparam int G = 0;
`endif

    logic clk = 1'b0;
    logic rst_a_n;
    int   total = 0;
    int   bad   = 0;

    seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic [3:0]  rep;
        int          mode;      // 0 quiet, 1 random input noise, 2 start 0110 in cycle 2
        int          exp_done;  // cycle (relative to start edge) carrying done
        logic [63:0] exp_word;  // ser_out bits seen while busy, first bit in MSB
    } vec_t;

    // {ser_out, busy, frame_last, done}
    function automatic logic [3:0] outs();
        return {bus.ser_out, bus.busy, bus.frame_last, bus.done};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs are built from the frame/gap rules, then
    // compared against the DUT one cycle at a time.
    task automatic xfer(input logic [3:0] pat, input logic [3:0] rep, input int mode,
                        output int done_cyc, output logic [63:0] word, output logic [63:0] det);
        logic [3:0] q[$];
        logic [3:0] o;
        logic [2:0] hist;
        int         n;
        n = (rep == 4'd0) ? 1 : int'(rep);
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < PAT_W; b++)
                q.push_back({pat[PAT_W-1-b], 1'b1, (b == PAT_W-1), 1'b0});
            if (f < n - 1)
                for (int g = 0; g < G; g++) q.push_back(4'b0100);
        end
        q.push_back(4'b0001);
        q.push_back(4'b0000);
        done_cyc = -1;
        word     = '0;
        det      = '0;
        hist     = '0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.pattern    = pat;
        bus.repeat_cnt = rep;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            o = outs();
            chk($sformatf("cyc%0d", i + 1), 64'(o), 64'(q[i]));
            if (o[0] && done_cyc < 0) done_cyc = i + 1;
            if (o[2]) word = {word[62:0], o[3]};
            if (hist == 3'b100 && o[3]) det[i] = 1'b1;
            hist = {hist[1:0], o[3]};
            case (mode)
                1: begin
                    bus.start      = 1'($urandom);
                    bus.pattern    = 4'($urandom);
                    bus.repeat_cnt = 4'($urandom);
                end
                2: begin
                    bus.start   = (i == 1);
                    bus.pattern = 4'b0110;
                end
                default: bus.start = 1'b0;
            endcase
            if (i == q.size() - 1) bus.start = 1'b0;
        end
    endtask

    vec_t        tv[4];
    int          dc;
    logic [63:0] w;
    logic [63:0] dm;
    logic [3:0]  o6;
    logic        seen;

    initial begin
        tv[0] = '{pat: SEQ_PAT_1001, rep: 4'd1, mode: 0, exp_done: 5, exp_word: 64'h9};
`ifdef SEQ_GAP_EN
        tv[1] = '{pat: SEQ_PAT_1001, rep: 4'd3, mode: 0, exp_done: 17, exp_word: 64'h9249};
`else
        tv[1] = '{pat: SEQ_PAT_1001, rep: 4'd3, mode: 0, exp_done: 13, exp_word: 64'h999};
`endif
        tv[2] = '{pat: SEQ_PAT_1001, rep: 4'd1, mode: 2, exp_done: 5, exp_word: 64'h9};
        tv[3] = '{pat: 4'b1010,      rep: 4'd0, mode: 0, exp_done: 5, exp_word: 64'hA};

        rst_a_n        = 1'b0;
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        #2;
        chk("reset_outs", 64'(outs()), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'(outs()), 64'h0);

        // Asynchronous reset in the middle of a frame, between clock edges
        bus.start      = 1'b1;
        bus.pattern    = SEQ_PAT_1001;
        bus.repeat_cnt = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", 64'(bus.busy), 64'h1);
        @(posedge clk);
        #3;
        rst_a_n = 1'b0;
        #1;
        chk("rst_async", 64'(outs()), 64'h0);
        @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", 64'(outs()), 64'h0);

        // Vector table
        for (int r = 0; r < 4; r++) begin
            xfer(tv[r].pat, tv[r].rep, tv[r].mode, dc, w, dm);
            chk($sformatf("done_cyc_v%0d", r), 64'(dc), 64'(tv[r].exp_done));
            chk($sformatf("word_v%0d", r), w, tv[r].exp_word);
            if (r == 0) chk("det1001_loopback", dm, 64'h8);
        end

        // Start held high through the DONE cycle: restart only from IDLE
        @(negedge clk);
        bus.start      = 1'b1;
        bus.pattern    = 4'b1010;
        bus.repeat_cnt = 4'd0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            o6 = outs();
            if (c == 5) chk("hold_done", 64'(o6), 64'h1);
            if (c == 6) chk("hold_idle", 64'(o6), 64'h0);
            if (c == 7) chk("hold_restart", 64'(o6), 64'hC);
        end
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("restart_done", 64'(seen), 64'h1);
        @(negedge clk);

        // Randomized transfers with input noise during the transfer
        for (int k = 0; k < 20; k++) begin
            xfer(4'($urandom), 4'($urandom_range(0, 5)), 1, dc, w, dm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
